// File: rtl/axi_mux_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// axi_mux_sweep_ctrl
//
// Sequencer for the 7-input wavelet/FFT output mux. It drives the mux one-hot
// selector, walks the enabled channels round-robin and forwards frame_len valid
// samples per channel as one AXI-Stream frame terminated by tlast.
//
// Optional feature macro: SWEEP_HDR_EN
//   defined   : every frame is preceded by one header beat
//               {ch index[3:0], frame_len, zeros}, tvalid=1, tlast=0, issued
//               from the last settle cycle (frame length on stream = len+1).
//   undefined : frames carry samples only; no header logic is built.
//
// Ports
//   clk            in   1                 system clock, rising edge
//   aresetn        in   1                 asynchronous active-low reset
//   start          in   1                 one-cycle pulse, begin a sweep
//   continuous     in   1                 1: restart after the last channel
//   ch_mask        in   NUM_CH            channel enables, bit i = mux input i
//   frame_len      in   LEN_WIDTH         samples per channel frame (0 -> 1)
//   mux_tdata      in   AXIS_TDATA_WIDTH  mux output data
//   mux_tvalid     in   1                 mux output valid
//   selector       out  GPIO_SIZE         mux selector, one-hot or zero
//   m_axis_tdata   out  AXIS_TDATA_WIDTH  stream data to DMA
//   m_axis_tvalid  out  1                 stream valid
//   m_axis_tready  in   1                 stream ready (only monitored)
//   m_axis_tlast   out  1                 last beat of each channel frame
//   busy           out  1                 sweep in progress
//   done           out  1                 one-cycle pulse at end of sweep
//   overflow       out  1                 sticky: beat presented while !tready
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axi_mux_sweep_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int GPIO_SIZE        = 32,
    parameter int NUM_CH           = 7,
    parameter int LEN_WIDTH        = 16,
    parameter int SETTLE_CYCLES    = 2
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        start,
    input  logic                        continuous,
    input  logic [NUM_CH-1:0]           ch_mask,
    input  logic [LEN_WIDTH-1:0]        frame_len,
    input  logic [AXIS_TDATA_WIDTH-1:0] mux_tdata,
    input  logic                        mux_tvalid,
    output logic [GPIO_SIZE-1:0]        selector,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // A settle length of zero still spends one cycle in SETTLE.
    localparam logic [SET_W-1:0] SETTLE_LAST =
        SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_CAPTURE,
        S_NEXT
    } state_t;

    state_t                      r_state;
    logic [NUM_CH-1:0]           r_mask;
    logic [LEN_WIDTH-1:0]        r_len;
    logic                        r_cont;
    logic [CH_W-1:0]             r_ch;
    logic [SET_W-1:0]            r_settle_cnt;
    logic [LEN_WIDTH-1:0]        r_sample_cnt;
    logic [GPIO_SIZE-1:0]        r_selector;
    logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic                        r_tvalid;
    logic                        r_tlast;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_overflow;

    logic [NUM_CH-1:0]           w_above;
    logic [CH_W-1:0]             w_first_ch;
    logic [CH_W-1:0]             w_next_ch;
    logic [CH_W-1:0]             w_wrap_ch;
    logic                        w_next_found;
    logic [GPIO_SIZE-1:0]        w_onehot;
    logic [LEN_WIDTH-1:0]        w_len_eff;
    logic [LEN_WIDTH-1:0]        w_cnt_inc;

    // -------------------------------------------------------------------------
    // Channel search helpers
    // -------------------------------------------------------------------------
    // Enabled channels strictly above the current one; channel 0 can never be
    // above anything, so it is tied off instead of compared.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_above
            if (gi == 0) begin : g_zero
                assign w_above[gi] = 1'b0;
            end else begin : g_cmp
                assign w_above[gi] = r_mask[gi] && (r_ch < CH_W'(gi));
            end
        end
    endgenerate

    assign w_next_found = |w_above;

    // Lowest-index priority encoders: scanning downward leaves the lowest hit.
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_wrap_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) w_first_ch = CH_W'(i);
            if (w_above[i]) w_next_ch  = CH_W'(i);
            if (r_mask[i])  w_wrap_ch  = CH_W'(i);
        end
    end

    // Selector decode; bits at or above NUM_CH are hard zero.
    generate
        for (gi = 0; gi < GPIO_SIZE; gi++) begin : g_sel
            if (gi < NUM_CH) begin : g_live
                assign w_onehot[gi] = (r_ch == CH_W'(gi));
            end else begin : g_dead
                assign w_onehot[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_len_eff = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
    assign w_cnt_inc = r_sample_cnt + LEN_WIDTH'(1);

`ifdef SWEEP_HDR_EN
    localparam int HDR_PAD = AXIS_TDATA_WIDTH - 4 - LEN_WIDTH;
    logic [AXIS_TDATA_WIDTH-1:0] w_hdr;
    assign w_hdr = {4'(r_ch), r_len, {HDR_PAD{1'b0}}};
`endif

    // -------------------------------------------------------------------------
    // Sweep FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_len        <= '0;
            r_cont       <= 1'b0;
            r_ch         <= '0;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_selector   <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // Stream beats and done are single-cycle unless re-asserted below.
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_done   <= 1'b0;

            // The mux cannot be stalled, so a refused beat is lost; flag it.
            if (r_tvalid && !m_axis_tready) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        r_mask     <= ch_mask;
                        r_len      <= w_len_eff;
                        r_cont     <= continuous;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ch       <= w_first_ch;
                        r_state    <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    r_selector   <= w_onehot;
                    r_settle_cnt <= '0;
                    r_sample_cnt <= '0;
                    r_state      <= S_SETTLE;
                end

                // Mux pipeline still holds the previous channel: discard it.
                S_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= S_CAPTURE;
`ifdef SWEEP_HDR_EN
                        r_tdata  <= w_hdr;
                        r_tvalid <= 1'b1;
`endif
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SET_W'(1);
                    end
                end

                S_CAPTURE: begin
                    if (mux_tvalid) begin
                        r_tdata      <= mux_tdata;
                        r_tvalid     <= 1'b1;
                        r_sample_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            r_tlast    <= 1'b1;
                            r_selector <= '0;
                            r_state    <= S_NEXT;
                        end
                    end
                end

                S_NEXT: begin
                    if (w_next_found) begin
                        r_ch    <= w_next_ch;
                        r_state <= S_SELECT;
                    end else begin
                        r_ch <= w_wrap_ch;
                        // Live continuous is re-checked at every wrap so that
                        // dropping it ends the sweep after the current pass.
                        if (r_cont && continuous) begin
                            r_state <= S_SELECT;
                        end else begin
                            r_cont  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign selector      = r_selector;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign overflow      = r_overflow;

endmodule
